// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetcher: issues BRAM reads, registers the returned
// word and hands it to decode with instr_valid until the PC control logic strobes an update.
module pc_fetch_unit #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned INSTR_W = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [PC_W:0]      i_prog_len,
  input  logic               i_clken_pc,
  input  logic               i_load_pc,
  input  logic               i_incr_pc,
  input  logic [PC_W-1:0]    i_load_value_pc,
  output logic               o_imem_en,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_oob
);

  typedef enum logic [1:0] {StIdle, StWait, StRun, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [PC_W-1:0]    r_pc, w_pc_d;
  logic [INSTR_W-1:0] r_instr, w_instr_d;
  logic               r_valid, w_valid_d;
  logic               r_done;
  logic               r_err, w_err_d;
  logic               w_imem_en;
  logic [PC_W-1:0]    w_imem_addr;
  logic [PC_W:0]      w_next_pc;

  // One extra bit so pc+1 at the top of the address space reaches prog_len instead of wrapping.
  always_comb begin
    if (i_load_pc) begin
      w_next_pc = {1'b0, i_load_value_pc};
    end else begin
      w_next_pc = {1'b0, r_pc} + {{PC_W{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_instr_d   = r_instr;
    w_valid_d   = r_valid;
    w_err_d     = r_err;
    w_imem_en   = 1'b0;
    w_imem_addr = r_pc;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_err_d = 1'b0;
          if (i_prog_len != '0) begin
            w_imem_en   = 1'b1;
            w_imem_addr = '0;
            w_pc_d      = '0;
            w_state_d   = StWait;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StWait: begin
        w_instr_d = i_imem_rdata;
        w_valid_d = 1'b1;
        w_state_d = StRun;
      end
      StRun: begin
        if (i_clken_pc && (i_load_pc || i_incr_pc)) begin
          if (i_load_pc && (w_next_pc >= i_prog_len)) begin
            w_err_d   = 1'b1;
            w_valid_d = 1'b0;
            w_state_d = StDone;
          end else if (!i_load_pc && (w_next_pc == i_prog_len)) begin
            w_valid_d = 1'b0;
            w_state_d = StDone;
          end else begin
            w_imem_en   = 1'b1;
            w_imem_addr = w_next_pc[PC_W-1:0];
            w_pc_d      = w_next_pc[PC_W-1:0];
            w_valid_d   = 1'b0;
            w_state_d   = StWait;
          end
        end
      end
      StDone: begin
        w_valid_d = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_valid <= w_valid_d;
      r_done  <= (w_state_d == StDone);
      r_err   <= w_err_d;
    end
  end

  assign o_imem_en     = w_imem_en & ~i_rst;
  assign o_imem_addr   = w_imem_addr;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_valid;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_err_oob     = r_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit with a one-cycle-latency BRAM model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] prog_len;
  logic        clken_pc;
  logic        load_pc;
  logic        incr_pc;
  logic [11:0] load_value_pc;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [63:0] imem_rdata;
  logic [11:0] pc;
  logic [63:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic        err_oob;

  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;

  pc_fetch_unit #(
    .PC_W   (12),
    .INSTR_W(64)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_prog_len     (prog_len),
    .i_clken_pc     (clken_pc),
    .i_load_pc      (load_pc),
    .i_incr_pc      (incr_pc),
    .i_load_value_pc(load_value_pc),
    .o_imem_en      (imem_en),
    .o_imem_addr    (imem_addr),
    .i_imem_rdata   (imem_rdata),
    .o_pc           (pc),
    .o_instr        (instr),
    .o_instr_valid  (instr_valid),
    .o_busy         (busy),
    .o_done         (done),
    .o_err_oob      (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each address holds a distinct, recognisable word.
  function automatic logic [63:0] word(input logic [11:0] a);
    return {20'hC0DE0, a, 20'h5A5A5, ~a};
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) if (imem_en) imem_rdata <= word(imem_addr);

  // ci: 0 = instr not checked, 1 = expect word(iaddr), 2 = expect zero.
  typedef struct {
    logic        rst;
    logic        start;
    logic [12:0] len;
    logic        ck;
    logic        ld;
    logic        inc;
    logic [11:0] lv;
    logic        e_en;
    logic [11:0] e_addr;
    logic [11:0] e_pc;
    logic        e_val;
    logic        e_done;
    logic        e_err;
    logic        e_busy;
    int          ci;
    logic [11:0] iaddr;
  } vec_t;

  vec_t lin[$];
  vec_t cor[$];

  function automatic vec_t mk(input bit r, input bit st, input int len, input bit ck,
                              input bit ld, input bit inc, input int lv, input bit e_en,
                              input int e_addr, input int e_pc, input bit e_val,
                              input bit e_done, input bit e_err, input bit e_busy,
                              input int ci, input int iaddr);
    vec_t v;
    v.rst = r;  v.start = st;  v.len = 13'(len);  v.ck = ck;  v.ld = ld;  v.inc = inc;
    v.lv = 12'(lv);  v.e_en = e_en;  v.e_addr = 12'(e_addr);  v.e_pc = 12'(e_pc);
    v.e_val = e_val;  v.e_done = e_done;  v.e_err = e_err;  v.e_busy = e_busy;
    v.ci = ci;  v.iaddr = 12'(iaddr);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    start         = v.start;
    prog_len      = v.len;
    clken_pc      = v.ck;
    load_pc       = v.ld;
    incr_pc       = v.inc;
    load_value_pc = v.lv;
    #1;
    chk({tag, ".imem_en"}, idx, 64'(imem_en), 64'(v.e_en));
    if (v.e_en) chk({tag, ".imem_addr"}, idx, 64'(imem_addr), 64'(v.e_addr));
    chk({tag, ".pc"}, idx, 64'(pc), 64'(v.e_pc));
    chk({tag, ".instr_valid"}, idx, 64'(instr_valid), 64'(v.e_val));
    chk({tag, ".done"}, idx, 64'(done), 64'(v.e_done));
    chk({tag, ".err_oob"}, idx, 64'(err_oob), 64'(v.e_err));
    chk({tag, ".busy"}, idx, 64'(busy), 64'(v.e_busy));
    if (v.ci == 1) chk({tag, ".instr"}, idx, instr, word(v.iaddr));
    if (v.ci == 2) chk({tag, ".instr"}, idx, instr, 64'd0);
  endtask

  initial begin
    //                 rst st len ck ld in lv   en addr pc val dn er by ci ia
    lin.push_back(mk(0, 1, 4, 0, 0, 0, 0,    1, 0,    0, 0, 0, 0, 0, 2, 0));
    lin.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    1, 1,    0, 1, 0, 0, 1, 1, 0));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    0, 0,    1, 0, 0, 0, 1, 0, 0));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    1, 2,    1, 1, 0, 0, 1, 1, 1));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    0, 0,    2, 0, 0, 0, 1, 0, 0));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    1, 3,    2, 1, 0, 0, 1, 1, 2));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    0, 0,    3, 0, 0, 0, 1, 0, 0));
    lin.push_back(mk(0, 0, 4, 1, 0, 1, 0,    0, 0,    3, 1, 0, 0, 1, 1, 3));
    lin.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    3, 0, 1, 0, 1, 0, 0));
    lin.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    3, 0, 0, 0, 0, 0, 0));

    // Branch with load winning over incr.
    cor.push_back(mk(0, 1, 4, 0, 0, 0, 0,    1, 0,    3, 0, 0, 0, 0, 0, 0));
    cor.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 4, 1, 0, 1, 0,    1, 1,    0, 1, 0, 0, 1, 1, 0));
    cor.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    1, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 4, 1, 0, 1, 0,    1, 2,    1, 1, 0, 0, 1, 1, 1));
    cor.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    2, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 4, 1, 1, 1, 0,    1, 0,    2, 1, 0, 0, 1, 1, 2));
    cor.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    // Five-cycle stall: load/incr/start asserted but clken low.
    for (int k = 0; k < 5; k++)
      cor.push_back(mk(0, 1, 4, 0, 1, 1, 3,  0, 0,    0, 1, 0, 0, 1, 1, 0));
    cor.push_back(mk(0, 0, 4, 1, 0, 0, 3,    0, 0,    0, 1, 0, 0, 1, 1, 0));
    // Out-of-bounds branches, sticky error, cleared by next start.
    cor.push_back(mk(0, 0, 4, 1, 1, 0, 4,    0, 0,    0, 1, 0, 0, 1, 1, 0));
    cor.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    0, 0, 1, 1, 1, 0, 0));
    cor.push_back(mk(0, 1, 8, 0, 0, 0, 0,    1, 0,    0, 0, 0, 1, 0, 0, 0));
    cor.push_back(mk(0, 0, 8, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 8, 1, 1, 0, 9,    0, 0,    0, 1, 0, 0, 1, 1, 0));
    cor.push_back(mk(0, 0, 8, 0, 0, 0, 0,    0, 0,    0, 0, 1, 1, 1, 0, 0));
    cor.push_back(mk(0, 1, 8, 0, 0, 0, 0,    1, 0,    0, 0, 0, 1, 0, 0, 0));
    cor.push_back(mk(0, 0, 8, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    // In-range branch to the last PC, then incr ends the program.
    cor.push_back(mk(0, 0, 8, 1, 1, 0, 7,    1, 7,    0, 1, 0, 0, 1, 1, 0));
    cor.push_back(mk(0, 0, 8, 0, 0, 0, 0,    0, 0,    7, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 8, 1, 0, 1, 0,    0, 0,    7, 1, 0, 0, 1, 1, 7));
    cor.push_back(mk(0, 0, 8, 0, 0, 0, 0,    0, 0,    7, 0, 1, 0, 1, 0, 0));
    // Empty program.
    cor.push_back(mk(0, 1, 0, 0, 0, 0, 0,    0, 0,    7, 0, 0, 0, 0, 0, 0));
    cor.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0,    7, 0, 1, 0, 1, 0, 0));
    // Full 4096-entry program: no wrap past 4095.
    cor.push_back(mk(0, 1, 4096, 0, 0, 0, 0,    1, 0,    7, 0, 0, 0, 0, 0, 0));
    cor.push_back(mk(0, 0, 4096, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 4096, 1, 1, 0, 4095, 1, 4095, 0, 1, 0, 0, 1, 1, 0));
    cor.push_back(mk(0, 0, 4096, 0, 0, 0, 0,    0, 0, 4095, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(0, 0, 4096, 1, 0, 1, 0,    0, 0, 4095, 1, 0, 0, 1, 1, 4095));
    cor.push_back(mk(0, 0, 4096, 0, 0, 0, 0,    0, 0, 4095, 0, 1, 0, 1, 0, 0));
    // Reset while a read is in flight; the returning word must not be captured.
    cor.push_back(mk(0, 1, 4, 0, 0, 0, 0,    1, 0, 4095, 0, 0, 0, 0, 0, 0));
    cor.push_back(mk(1, 0, 4, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 1, 0, 0));
    cor.push_back(mk(1, 1, 4, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 0, 2, 0));
    cor.push_back(mk(0, 0, 4, 0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 0, 2, 0));

    rst = 1'b1;  start = 1'b0;  prog_len = '0;  clken_pc = 1'b0;
    load_pc = 1'b0;  incr_pc = 1'b0;  load_value_pc = '0;
    repeat (2) @(posedge clk);

    foreach (lin[i]) begin
      run_vec("lin", i, lin[i]);
      if (instr_valid) nvalid++;
    end
    chk("lin.valid_count", 0, 64'(nvalid), 64'd4);

    foreach (cor[i]) run_vec("cor", i, cor[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
